// File: rtl/ahb_bus_decoder.sv
// AHB-Lite single-master address decoder and response multiplexer with a built-in
// default slave. The optional stalled-slave watchdog is enabled by defining AHB_BUS_TIMEOUT_EN.
module ahb_bus_decoder #(
    parameter int SLAVE_COUNT    = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int REGION_LSB     = 28,
    parameter int SPAN_BITS      = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            m_hsel,
    input  logic [ADDR_WIDTH-1:0]           m_haddr,
    input  logic [1:0]                      m_htrans,
    input  logic                            m_hwrite,
    input  logic [2:0]                      m_hsize,
    input  logic [2:0]                      m_hburst,
    input  logic [DATA_WIDTH-1:0]           m_hwdata,
    output logic [DATA_WIDTH-1:0]           m_hrdata,
    output logic                            m_hready,
    output logic [1:0]                      m_hresp,
    output logic [SLAVE_COUNT-1:0]          s_hsel,
    output logic [ADDR_WIDTH-1:0]           s_haddr,
    output logic [1:0]                      s_htrans,
    output logic                            s_hwrite,
    output logic [2:0]                      s_hsize,
    output logic [2:0]                      s_hburst,
    output logic [DATA_WIDTH-1:0]           s_hwdata,
    output logic                            s_hready,
    input  logic [SLAVE_COUNT*DATA_WIDTH-1:0] s_hrdata,
    input  logic [SLAVE_COUNT-1:0]          s_hreadyout,
    input  logic [SLAVE_COUNT*2-1:0]        s_hresp,
    output logic [15:0]                     err_cnt,
    output logic [ADDR_WIDTH-1:0]           err_addr,
    output logic [SLAVE_COUNT-1:0]          timeout_status
);

    localparam int GAP_W = REGION_LSB - SPAN_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ERR1 = 2'd1,
        ST_ERR2 = 2'd2
    } err_state_t;

    err_state_t              state_r, state_nxt_s;
    logic                    valid_s, gap_ok_s, mapped_s, unmapped_acc_s, fire_s;
    logic [3:0]              idx_s;
    logic                    d_act_r, d_def_r;
    logic [3:0]              d_idx_r;
    logic [ADDR_WIDTH-1:0]   d_addr_r;
    logic [DATA_WIDTH-1:0]   sel_rdata_s;
    logic                    sel_ready_s;
    logic [1:0]              sel_resp_s;
    logic [15:0]             err_cnt_r;
    logic [ADDR_WIDTH-1:0]   err_addr_r;

    assign s_haddr  = m_haddr;
    assign s_htrans = m_htrans;
    assign s_hwrite = m_hwrite;
    assign s_hsize  = m_hsize;
    assign s_hburst = m_hburst;
    assign s_hwdata = m_hwdata;
    assign s_hready = m_hready;
    assign err_cnt  = err_cnt_r;
    assign err_addr = err_addr_r;

    // Address-phase decode; timed-out regions fall through to the default slave.
    always_comb begin
        valid_s  = m_hsel & m_htrans[1];
        idx_s    = m_haddr[REGION_LSB +: 4];
        gap_ok_s = (m_haddr[SPAN_BITS +: GAP_W] == '0);
        mapped_s = 1'b0;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            mapped_s = mapped_s | ((idx_s == 4'(i)) & gap_ok_s & ~timeout_status[i]);
        end
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            s_hsel[i] = m_hsel & mapped_s & (idx_s == 4'(i));
        end
    end

    assign unmapped_acc_s = valid_s & ~mapped_s & m_hready;

    // Select the response of the slave owning the current data phase.
    always_comb begin
        sel_rdata_s = '0;
        sel_ready_s = 1'b0;
        sel_resp_s  = 2'b00;
        for (int i = 0; i < SLAVE_COUNT; i++) begin
            sel_rdata_s = sel_rdata_s | (s_hrdata[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{d_idx_r == 4'(i)}});
            sel_ready_s = sel_ready_s | (s_hreadyout[i] & (d_idx_r == 4'(i)));
            sel_resp_s  = sel_resp_s  | (s_hresp[2*i +: 2] & {2{d_idx_r == 4'(i)}});
        end
    end

    // Master-side response: the error FSM overrides any mapped slave.
    always_comb begin
        m_hrdata = (d_act_r & ~d_def_r) ? sel_rdata_s : '0;
        m_hready = 1'b1;
        m_hresp  = 2'b00;
        case (state_r)
            ST_ERR1: begin
                m_hready = 1'b0;
                m_hresp  = 2'b01;
            end
            ST_ERR2: begin
                m_hready = 1'b1;
                m_hresp  = 2'b01;
            end
            default: begin
                if (d_act_r & ~d_def_r) begin
                    m_hready = sel_ready_s;
                    m_hresp  = sel_resp_s;
                end else begin
                    m_hready = 1'b1;
                    m_hresp  = 2'b00;
                end
            end
        endcase
    end

    // Error FSM next state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (unmapped_acc_s | fire_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ERR1: state_nxt_s = ST_ERR2;
            ST_ERR2: begin
                if (unmapped_acc_s) begin
                    state_nxt_s = ST_ERR1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Error FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Data-phase context advances only when the bus is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_act_r  <= 1'b0;
            d_def_r  <= 1'b0;
            d_idx_r  <= 4'd0;
            d_addr_r <= '0;
        end else if (m_hready) begin
            d_act_r  <= valid_s;
            d_def_r  <= ~mapped_s;
            d_idx_r  <= idx_s;
            d_addr_r <= m_haddr;
        end
    end

    // Error log; a watchdog fault reports the stalled data-phase address.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_r  <= 16'd0;
            err_addr_r <= '0;
        end else if ((state_nxt_s == ST_ERR1) && (state_r != ST_ERR1)) begin
            err_cnt_r  <= (err_cnt_r == 16'hFFFF) ? err_cnt_r : err_cnt_r + 16'd1;
            err_addr_r <= fire_s ? d_addr_r : m_haddr;
        end
    end

`ifdef AHB_BUS_TIMEOUT_EN
    logic [7:0]             wd_cnt_r;
    logic [SLAVE_COUNT-1:0] tmo_r;
    logic                   stall_s;

    assign stall_s        = (state_r == ST_IDLE) & d_act_r & ~d_def_r & ~sel_ready_s;
    assign fire_s         = stall_s & (wd_cnt_r == 8'(TIMEOUT_CYCLES - 1));
    assign timeout_status = tmo_r;

    // Watchdog: counts consecutive stalled mapped data-phase cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_r <= 8'd0;
            tmo_r    <= '0;
        end else if (fire_s) begin
            wd_cnt_r <= 8'd0;
            for (int i = 0; i < SLAVE_COUNT; i++) begin
                if (d_idx_r == 4'(i)) begin
                    tmo_r[i] <= 1'b1;
                end
            end
        end else if (stall_s) begin
            wd_cnt_r <= wd_cnt_r + 8'd1;
        end else begin
            wd_cnt_r <= 8'd0;
        end
    end
`else
    assign fire_s         = 1'b0;
    assign timeout_status = '0;
`endif

endmodule

// File: tb/tb_ahb_bus_decoder.sv
// Self-checking bench for ahb_bus_decoder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a transfer-level model.
module tb_ahb_bus_decoder;

    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         m_hsel = 1'b0;
    logic [31:0]  m_haddr = 32'd0;
    logic [1:0]   m_htrans = 2'b00;
    logic         m_hwrite = 1'b0;
    logic [2:0]   m_hsize = 3'd2;
    logic [2:0]   m_hburst = 3'd0;
    logic [31:0]  m_hwdata = 32'd0;
    logic [31:0]  m_hrdata;
    logic         m_hready;
    logic [1:0]   m_hresp;
    logic [3:0]   s_hsel;
    logic [31:0]  s_haddr;
    logic [1:0]   s_htrans;
    logic         s_hwrite;
    logic [2:0]   s_hsize;
    logic [2:0]   s_hburst;
    logic [31:0]  s_hwdata;
    logic         s_hready;
    logic [127:0] sl_rdata = 128'd0;
    logic [3:0]   sl_ready = 4'hF;
    logic [7:0]   sl_resp = 8'd0;
    logic [15:0]  err_cnt;
    logic [31:0]  err_addr;
    logic [3:0]   timeout_status;

    int pass_cnt = 0;
    int total_cnt = 0;

    ahb_bus_decoder dut (
        .clk(clk), .rst(rst), .m_hsel(m_hsel), .m_haddr(m_haddr), .m_htrans(m_htrans),
        .m_hwrite(m_hwrite), .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hwdata(m_hwdata),
        .m_hrdata(m_hrdata), .m_hready(m_hready), .m_hresp(m_hresp), .s_hsel(s_hsel),
        .s_haddr(s_haddr), .s_htrans(s_htrans), .s_hwrite(s_hwrite), .s_hsize(s_hsize),
        .s_hburst(s_hburst), .s_hwdata(s_hwdata), .s_hready(s_hready), .s_hrdata(sl_rdata),
        .s_hreadyout(sl_ready), .s_hresp(sl_resp), .err_cnt(err_cnt), .err_addr(err_addr),
        .timeout_status(timeout_status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Transfer-level model: what kind of transfer owns the current data phase.
    int          mk = 0;      // 0 none, 1 mapped slave, 2 default-slave error
    int          mstep = 0;   // error cycle 1 or 2
    int          msidx = 0;
    bit          mwd = 1'b0;  // error raised by watchdog on a mapped slave
    logic [31:0] mdaddr = 32'd0;
    int          mstall = 0;
    logic [15:0] mcnt = 16'd0;
    logic [31:0] maddr = 32'd0;
    logic [3:0]  mtmo = 4'd0;
    bit          last_acc = 1'b1;

    function automatic bit mapped_f(input logic [31:0] a);
        logic [3:0] idx;
        idx = a[31:28];
        if (idx >= 4'd4 || a[27:16] != 12'd0) return 1'b0;
        return rst ? 1'b1 : !mtmo[idx[1:0]];
    endfunction

    function automatic logic exp_ready_f();
        if (rst || mk == 0) return 1'b1;
        if (mk == 1) return sl_ready[msidx];
        return (mstep == 2);
    endfunction

    function automatic logic [1:0] exp_resp_f();
        if (rst || mk == 0) return 2'b00;
        if (mk == 1) return sl_resp[2*msidx +: 2];
        return 2'b01;
    endfunction

    function automatic logic [31:0] exp_rdata_f();
        if (rst) return 32'd0;
        if (mk == 1 || (mk == 2 && mwd)) return sl_rdata[32*msidx +: 32];
        return 32'd0;
    endfunction

    // Model advance on each clock edge.
    always @(posedge clk) begin
        bit r;
        if (rst) begin
            mk = 0; mstep = 0; mwd = 1'b0; mstall = 0; mcnt = 16'd0; maddr = 32'd0;
            mtmo = 4'd0; mdaddr = 32'd0; last_acc = 1'b1;
        end else begin
            r = exp_ready_f();
            if (mk == 2 && mstep == 1) begin
                mstep = 2;
            end else if (r) begin
                mstall = 0;
                mwd = 1'b0;
                if (m_hsel && m_htrans[1]) begin
                    if (mapped_f(m_haddr)) begin
                        mk = 1; msidx = int'(m_haddr[29:28]); mdaddr = m_haddr;
                    end else begin
                        mk = 2; mstep = 1;
                        if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                        maddr = m_haddr;
                    end
                end else begin
                    mk = 0;
                end
            end else if (mk == 1) begin
                mstall++;
`ifdef AHB_BUS_TIMEOUT_EN
                if (mstall == TMO) begin
                    mtmo[msidx] = 1'b1; mk = 2; mstep = 1; mwd = 1'b1; mstall = 0;
                    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                    maddr = mdaddr;
                end
`endif
            end
            last_acc = r;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        logic [3:0] eh;
        eh = (m_hsel && mapped_f(m_haddr)) ? (4'd1 << m_haddr[29:28]) : 4'd0;
        chk("m_hready", m_hready, exp_ready_f());
        chk("m_hresp", m_hresp, exp_resp_f());
        chk("m_hrdata", m_hrdata, exp_rdata_f());
        chk("s_hsel", s_hsel, eh);
        chk("s_hready", s_hready, exp_ready_f());
        chk("s_haddr", s_haddr, m_haddr);
        chk("err_cnt", err_cnt, rst ? 16'd0 : mcnt);
        chk("err_addr", err_addr, rst ? 32'd0 : maddr);
        chk("timeout_status", timeout_status, rst ? 4'd0 : mtmo);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [31:0] a, input logic [1:0] tr, input logic wr);
        m_hsel = sel; m_haddr = a; m_htrans = tr; m_hwrite = wr; m_hwdata = $urandom;
    endtask

    initial begin
        int n;
        @(negedge clk);
        chk("rst_hready", m_hready, 1'b1);
        chk("rst_hresp", m_hresp, 2'b00);
        chk("rst_err_cnt", err_cnt, 16'd0);
        tick();
        rst = 1'b0;

        // zero-wait read from slave 2
        sl_rdata[95:64] = 32'hCAFE_0001;
        drive(1'b1, 32'h2000_0004, 2'b10, 1'b0);
        @(negedge clk); chk("t1_hsel", s_hsel, 4'b0100);
        tick(); drive(1'b1, 32'h0, 2'b00, 1'b0);
        @(negedge clk); chk("t1_rdata", m_hrdata, 32'hCAFE_0001); chk("t1_ready", m_hready, 1'b1);
        tick();

        // slave 0 with two wait states, slave 1 address phase held
        drive(1'b1, 32'h0000_0000, 2'b10, 1'b0);
        tick(); drive(1'b1, 32'h1000_0000, 2'b10, 1'b0); sl_ready[0] = 1'b0;
        @(negedge clk); chk("t2_wait1", m_hready, 1'b0); chk("t2_hsel", s_hsel, 4'b0010);
        tick();
        @(negedge clk); chk("t2_wait2", m_hready, 1'b0);
        tick(); sl_ready[0] = 1'b1; sl_rdata[31:0] = 32'h1111_0000;
        @(negedge clk); chk("t2_rd0", m_hrdata, 32'h1111_0000); chk("t2_rdy0", m_hready, 1'b1);
        tick(); drive(1'b1, 32'h0, 2'b00, 1'b0); sl_rdata[63:32] = 32'h2222_0000;
        @(negedge clk); chk("t2_rd1", m_hrdata, 32'h2222_0000);
        tick();

        // unmapped write: idx 5
        drive(1'b1, 32'h5000_0000, 2'b10, 1'b1);
        @(negedge clk); chk("t3_hsel", s_hsel, 4'b0000);
        tick(); drive(1'b1, 32'h0, 2'b00, 1'b0);
        @(negedge clk); chk("t3_err1_rdy", m_hready, 1'b0); chk("t3_err1_resp", m_hresp, 2'b01);
        tick();
        @(negedge clk); chk("t3_err2_rdy", m_hready, 1'b1); chk("t3_err2_resp", m_hresp, 2'b01);
        chk("t3_cnt", err_cnt, 16'd1); chk("t3_addr", err_addr, 32'h5000_0000);
        tick();

        // gap-bit fault followed back-to-back by another unmapped read (count is cumulative)
        drive(1'b1, 32'h1002_0000, 2'b10, 1'b0);
        tick(); drive(1'b1, 32'h8000_0000, 2'b10, 1'b0);
        @(negedge clk); chk("t4_err1a", m_hready, 1'b0);
        tick();
        @(negedge clk); chk("t4_err2a", m_hresp, 2'b01); chk("t4_addr_a", err_addr, 32'h1002_0000);
        tick(); drive(1'b1, 32'h0, 2'b00, 1'b0);
        @(negedge clk); chk("t4_err1b", m_hready, 1'b0); chk("t4_resp1b", m_hresp, 2'b01);
        tick();
        @(negedge clk); chk("t4_cnt", err_cnt, 16'd3); chk("t4_addr_b", err_addr, 32'h8000_0000);
        tick();

        // reset asserted in the middle of ERR1
        drive(1'b1, 32'h5000_0000, 2'b10, 1'b0);
        tick(); drive(1'b1, 32'h0, 2'b00, 1'b0);
        #1 rst = 1'b1;
        #1 chk("t6_hready", m_hready, 1'b1); chk("t6_hresp", m_hresp, 2'b00); chk("t6_cnt", err_cnt, 16'd0);
        tick(); rst = 1'b0;
        tick();

`ifdef AHB_BUS_TIMEOUT_EN
        // slave 3 stalls until the watchdog converts the transfer into an error
        sl_ready[3] = 1'b0;
        drive(1'b1, 32'h3000_0000, 2'b10, 1'b0);
        tick(); drive(1'b1, 32'h0, 2'b00, 1'b0);
        n = 0;
        @(negedge clk);
        while (n < 40 && m_hresp != 2'b01) begin
            n++;
            @(negedge clk);
        end
        chk("tmo_stall_cycles", n, TMO);
        chk("tmo_err1", m_hready, 1'b0);
        tick();
        tick(); sl_ready[3] = 1'b1;
        @(negedge clk); chk("tmo_status", timeout_status, 4'b1000);
        drive(1'b1, 32'h3000_0000, 2'b10, 1'b0);
        @(negedge clk); chk("tmo_hsel", s_hsel, 4'b0000);
        tick(); drive(1'b1, 32'h0, 2'b00, 1'b0);
        @(negedge clk); chk("tmo_dflt_err", m_hresp, 2'b01);
        tick(); tick();
`endif

        // randomized traffic; the master only changes after an accepted cycle
        for (int c = 0; c < 3000; c++) begin
            if (last_acc) begin
                logic [31:0] a;
                case ($urandom_range(3, 0))
                    0: a = {2'b00, 2'($urandom_range(3, 0)), 12'd0, 16'($urandom)};
                    1: a = {4'($urandom_range(15, 4)), 28'($urandom)};
                    2: a = {2'b00, 2'($urandom_range(3, 0)), 12'($urandom_range(4095, 1)), 16'($urandom)};
                    default: a = $urandom;
                endcase
                drive(($urandom_range(7, 0) != 0), a, 2'($urandom), 1'($urandom));
            end
            for (int s = 0; s < 4; s++) begin
                sl_ready[s] = ($urandom_range(3, 0) != 0);
                sl_resp[2*s +: 2] = {1'b0, ($urandom_range(15, 0) == 0)};
                sl_rdata[32*s +: 32] = $urandom;
            end
            tick();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
